// File: rtl/fetch_stage.sv
// Instruction fetch with integrated IF/ID register: credit-limited in-order imem requests,
// PC-tag queue, response FIFO, squash on redirect. Optional same-cycle bypass: FETCH_BYPASS_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imemReqValid,
  output logic [31:0] imemReqAddr,
  input  logic        imemReqReady,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        validD
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = BUF_DEPTH[CW:0];
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   fifo_instr_q [BUF_DEPTH];
  logic [31:0]   fifo_pc_q    [BUF_DEPTH];
  logic [31:0]   tag_q        [BUF_DEPTH];
  logic [PW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d, outst_q, outst_d, discard_q, discard_d;
  logic [31:0]   instr_q, instr_d, pc_q, pc_d, pc_plus4_q, pc_plus4_d;
  logic          valid_q, valid_d;

  logic [CW:0] inflight;
  logic        req_fire, resp_keep, resp_drop, fifo_empty, dec_adv;
  logic        bypass, fifo_push, fifo_pop;
  logic [31:0] load_instr, load_pc;

  // Occupancy plus outstanding never exceeds BUF_DEPTH, so every response has a slot.
  assign inflight     = {1'b0, fifo_cnt_q} + {1'b0, outst_q};
  assign imemReqValid = rst_n && !stallF && !PCSrcE && (inflight < DEPTH_W);
  assign imemReqAddr  = fetch_pc_q;
  assign req_fire     = imemReqValid && imemReqReady;

  assign resp_keep  = imemRespValid && (discard_q == '0);
  assign resp_drop  = imemRespValid && (discard_q != '0);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign dec_adv    = !PCSrcE && !flushD && !stallD;

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_keep && fifo_empty && dec_adv;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push  = resp_keep && !PCSrcE && !bypass;
  assign fifo_pop   = dec_adv && !fifo_empty;
  assign load_instr = bypass ? imemRespData : fifo_instr_q[fifo_rd_q];
  assign load_pc    = bypass ? tag_q[tag_rd_q] : fifo_pc_q[fifo_rd_q];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    fetch_pc_d = fetch_pc_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    discard_d  = discard_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(imemRespValid);
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;

    if (PCSrcE) begin
      // Everything already requested is stale; count it off as it returns.
      fetch_pc_d = PCTargetE;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      discard_d  = outst_q - CW'(imemRespValid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_wr_d   = tag_wr_q + PW'(1);
      end
      if (resp_keep) tag_rd_d = tag_rd_q + PW'(1);
      if (resp_drop) discard_d = discard_q - CW'(1);
      if (fifo_push) fifo_wr_d = fifo_wr_q + PW'(1);
      if (fifo_pop)  fifo_rd_d = fifo_rd_q + PW'(1);
      fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
    end

    if (PCSrcE || flushD) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end else if (!stallD) begin
      if (bypass || !fifo_empty) begin
        valid_d    = 1'b1;
        instr_d    = load_instr;
        pc_d       = load_pc;
        pc_plus4_d = load_pc + 32'd4;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      instr_q    <= NOP;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  // NOTE: storage arrays carry no reset; pointers and counts alone define which entries are live.
  always_ff @(posedge clk) begin
    if (req_fire) tag_q[tag_wr_q] <= fetch_pc_q;
    if (fifo_push) begin
      fifo_instr_q[fifo_wr_q] <= imemRespData;
      fifo_pc_q[fifo_wr_q]    <= tag_q[tag_rd_q];
    end
  end

  assign instrD   = instr_q;
  assign PCD      = pc_q;
  assign PCPlus4D = pc_plus4_q;
  assign validD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized hazards and memory
// timing, checked against a program-order stream model and an in-order memory model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallF, stallD, flushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imemReqValid, imemReqReady, imemRespValid;
  logic [31:0] imemReqAddr, imemRespData;
  logic [31:0] instrD, PCD, PCPlus4D;
  logic        validD;

  fetch_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr), .imemReqReady(imemReqReady),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .validD(validD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        memq[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          delivered = 0;
  logic [31:0] exp_req, exp_dec;

  bit          k_stallF, k_stallD, k_flushD, k_redir, k_ready;
  logic [31:0] k_target;
  int          k_lat;

  bit          prev_hold, prev_kill, fired;
  logic [31:0] prev_instr, prev_pc, prev_pc4, last_fire_addr;
  logic        prev_valid;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    exp_req   = RST_PC;
    exp_dec   = RST_PC;
    prev_hold = 1'b0;
    prev_kill = 1'b0;
    fired     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_validD"}, 32'(validD), 32'd0);
    check({tag, "_instrD"}, instrD, NOP);
    check({tag, "_PCD"}, PCD, 32'd0);
    check({tag, "_PCPlus4D"}, PCPlus4D, 32'd0);
    check({tag, "_reqValid"}, 32'(imemReqValid), 32'd0);
  endtask

  // Drives one cycle's inputs, samples outputs before the edge, advances the models.
  task automatic step_body();
    req_t r;
    stallF       = k_stallF;
    stallD       = k_stallD;
    flushD       = k_flushD;
    PCSrcE       = k_redir;
    PCTargetE    = k_target;
    imemReqReady = k_ready;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imemRespValid = 1'b1;
      imemRespData  = instr_of(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imemRespValid = 1'b0;
      imemRespData  = $urandom;
    end
    #1;
    if (prev_kill) begin
      check("kill_validD", 32'(validD), 32'd0);
      check("kill_instrD", instrD, NOP);
    end else if (prev_hold) begin
      check("hold_validD", 32'(validD), 32'(prev_valid));
      check("hold_instrD", instrD, prev_instr);
      check("hold_PCD", PCD, prev_pc);
      check("hold_PCPlus4D", PCPlus4D, prev_pc4);
    end
    if (validD) begin
      check("instr_matches_pc", instrD, instr_of(PCD));
      check("pcplus4", PCPlus4D, PCD + 32'd4);
    end
    if (stallF || PCSrcE) check("req_gated", 32'(imemReqValid), 32'd0);
    if (imemReqValid) check("req_addr", imemReqAddr, exp_req);
    fired = imemReqValid && imemReqReady;
    if (fired) begin
      r.addr = imemReqAddr;
      r.due  = cyc + 1 + k_lat;
      memq.push_back(r);
      last_fire_addr = imemReqAddr;
      check("outstanding_cap", 32'(memq.size() <= DEPTH), 32'd1);
    end
    if (PCSrcE) begin
      exp_req = PCTargetE;
      exp_dec = PCTargetE;
    end else begin
      if (fired) exp_req += 32'd4;
      if (validD) begin
        if (flushD) exp_dec += 32'd4;
        else if (!stallD) begin
          check("stream_PCD", PCD, exp_dec);
          exp_dec += 32'd4;
          delivered++;
        end
      end
    end
    prev_kill  = PCSrcE || flushD;
    prev_hold  = stallD && !prev_kill;
    prev_valid = validD;
    prev_instr = instrD;
    prev_pc    = PCD;
    prev_pc4   = PCPlus4D;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    step_body();
  endtask

  task automatic idle_knobs();
    k_stallF = 0; k_stallD = 0; k_flushD = 0; k_redir = 0;
    k_ready = 1; k_target = 32'd0; k_lat = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found, saw_fffc, saw_zero;
    bit due_ok;
    int base;

    // Reset state, with stallF low and credit free so only rst_n can hold the request off.
    idle_knobs();
    rst_n = 1'b0; stallF = 0; stallD = 0; flushD = 0; PCSrcE = 0; PCTargetE = '0;
    imemReqReady = 1; imemRespValid = 0; imemRespData = '0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step_body();
    check("first_req_valid", 32'(imemReqValid), 32'd1);
    check("first_req_addr", imemReqAddr, RST_PC);
    for (int i = 0; i < 11; i++) step();
    check("initial_throughput", 32'(delivered >= 3), 32'd1);

    // Memory not ready: address frozen, decode drains to a bubble.
    k_ready = 0;
    for (int i = 0; i < 4; i++) step();
    check("notready_drained", 32'(validD), 32'd0);
    check("notready_addr_frozen", imemReqAddr, exp_req);
    k_ready = 1;
    for (int i = 0; i < 4; i++) step();

    // Decode stall until the FIFO is full: no credit, outputs held.
    k_stallD = 1;
    for (int i = 0; i < 4; i++) step();
    check("stall_no_credit", 32'(imemReqValid), 32'd0);
    k_stallD = 0;
    for (int i = 0; i < 4; i++) step();

    // Redirect with two requests outstanding.
    k_lat = 4;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (memq.size() == 2) found = 1;
    end
    check("redir2_setup", 32'(found), 32'd1);
    k_redir = 1; k_target = 32'h0000_2000;
    step();
    k_redir = 0; k_lat = 0;
    step();
    check("redir2_bubble", 32'(validD), 32'd0);
    check("redir2_addr", imemReqAddr, 32'h0000_2000);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (validD) found = 1;
    end
    check("redir2_first_valid", 32'(found), 32'd1);
    check("redir2_first_pc", PCD, 32'h0000_2000);

    // Redirect coinciding with a response and a decode stall.
    k_stallF = 1; k_lat = 1;
    for (int i = 0; i < 8; i++) step();
    k_stallF = 0;
    step();
    step();
    due_ok = (memq.size() > 0) && (memq[0].due <= cyc);
    check("redirresp_setup_cnt", 32'(memq.size()), 32'd2);
    check("redirresp_setup_due", 32'(due_ok), 32'd1);
    k_redir = 1; k_target = 32'h0000_3000; k_stallD = 1;
    step();
    k_redir = 0; k_stallD = 0;
    step();
    check("redirresp_bubble", 32'(validD), 32'd0);
    check("redirresp_req_valid", 32'(imemReqValid), 32'd1);
    check("redirresp_req_addr", imemReqAddr, 32'h0000_3000);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (validD) found = 1;
    end
    check("redirresp_first_valid", 32'(found), 32'd1);
    check("redirresp_first_pc", PCD, 32'h0000_3000);

    // Fetch PC wraps past the top of the address space.
    k_lat = 0; k_redir = 1; k_target = 32'hFFFF_FFF8;
    step();
    k_redir = 0;
    saw_fffc = 0; saw_zero = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (fired && last_fire_addr == 32'd0) saw_zero = 1;
      if (validD && PCD == 32'hFFFF_FFFC && !saw_fffc) begin
        saw_fffc = 1;
        check("wrap_pcplus4", PCPlus4D, 32'h0000_0000);
      end
    end
    check("wrap_seen_fffc", 32'(saw_fffc), 32'd1);
    check("wrap_req_zero", 32'(saw_zero), 32'd1);

    // Asynchronous reset in the middle of traffic.
    k_lat = 2;
    for (int i = 0; i < 5; i++) step();
    #2;
    rst_n = 1'b0;
    imemRespValid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    idle_knobs();
    @(negedge clk);
    rst_n = 1'b1;
    step_body();
    check("midreset_restart_addr", imemReqAddr, RST_PC);
    for (int i = 0; i < 6; i++) step();

    // Randomized hazards, redirects and memory timing.
    base = delivered;
    for (int i = 0; i < 1500; i++) begin
      k_stallF = ($urandom_range(0, 7) == 0);
      k_stallD = ($urandom_range(0, 5) == 0);
      k_flushD = ($urandom_range(0, 15) == 0);
      k_redir  = ($urandom_range(0, 31) == 0);
      k_target = $urandom & 32'hFFFF_FFFC;
      k_ready  = ($urandom_range(0, 3) != 0);
      k_lat    = $urandom_range(0, 3);
      step();
    end
    check("random_progress", 32'(delivered - base > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
